// File: rtl/match_seq_gen_pkg.sv
// Shared definitions for the equal-pair sequence stimulus generator.
// Holds the FSM state encoding, the 2-bit symbol constants and the default match threshold.
// No logic lives here apart from the match predicate used by generator and tracker.
package match_seq_gen_pkg;

    // FSM state encoding (2-bit, legacy-compatible constants)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Symbols driven on w; 00/11 are matches, 01/10 are not
    localparam logic [1:0] SYM_00 = 2'b00;
    localparam logic [1:0] SYM_11 = 2'b11;
    localparam logic [1:0] SYM_01 = 2'b01;
    localparam logic [1:0] SYM_10 = 2'b10;

    // Consecutive matching samples after which the detector asserts z
    localparam int MIN_MATCH_DEF = 4;

    function automatic logic is_match(input logic [1:0] s);
        return s[1] == s[0];
    endfunction

endpackage

// File: rtl/match_seq_gen_match_tracker.sv
// Purpose: golden model of the detector output z, driven from the w stream.
// Latency: z_exp is registered, one edge after the sample that completes the run.
// Backpressure: none; samples w on every Clock edge.
// Ports: Clock, Reset (async, active-high), w (symbol in), z_exp (predicted z out).
module match_tracker
    import match_seq_gen_pkg::*;
#(
    parameter int MIN_MATCH = MIN_MATCH_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [1:0] w,
    output logic       z_exp
);

    localparam int MW = (MIN_MATCH > 1) ? $clog2(MIN_MATCH) : 1;
    localparam logic [MW-1:0] SAT = MW'(MIN_MATCH - 1);

    logic [MW-1:0] mcount;

    // mcount holds at SAT during long runs so z stays high instead of wrapping
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mcount <= '0;
            z_exp  <= 1'b0;
        end else if (is_match(w)) begin
            if (mcount != SAT) begin
                mcount <= mcount + MW'(1);
            end
            z_exp <= (mcount == SAT);
        end else begin
            mcount <= '0;
            z_exp  <= 1'b0;
        end
    end

endmodule

// File: rtl/match_seq_gen.sv
// Purpose: drives a run of matching symbols then a gap of alternating 01/10 to the detector, with expected z.
// Latency: first run symbol appears one edge after start; done pulses one edge after the last symbol.
// Backpressure: start is accepted only while ready=1; a start at any other time is dropped, not queued.
// Ports: Clock, Reset (async, active-high), start, run_len, sym, gap_len in;
//        ready, w, w_valid, z_exp, done out (all registered).
module match_seq_gen
    import match_seq_gen_pkg::*;
#(
    parameter int CW        = 4,
    parameter int MIN_MATCH = MIN_MATCH_DEF
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          start,
    input  logic [CW-1:0] run_len,
    input  logic          sym,
    input  logic [CW-1:0] gap_len,
    output logic          ready,
    output logic [1:0]    w,
    output logic          w_valid,
    output logic          z_exp,
    output logic          done
);

    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] gap_q, gap_n;
    logic          sym_q, sym_n;
    logic [1:0]    w_n;
    logic          vld_n, rdy_n, done_n;

    // Next state and next outputs are computed together so every output is a flop.
    // cnt is loaded with the phase length and the phase ends on the edge where cnt==1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap_q;
        sym_n   = sym_q;
        w_n     = SYM_01;
        vld_n   = 1'b0;
        rdy_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                rdy_n = 1'b1;
                if (start && ready) begin
                    sym_n = sym;
                    gap_n = gap_len;
                    rdy_n = 1'b0;
                    if (run_len != '0) begin
                        state_n = RUN;
                        cnt_n   = run_len;
                        w_n     = {sym, sym};
                        vld_n   = 1'b1;
                    end else if (gap_len != '0) begin
                        state_n = GAP;
                        cnt_n   = gap_len;
                        vld_n   = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    if (gap_q != '0) begin
                        state_n = GAP;
                        cnt_n   = gap_q;
                        vld_n   = 1'b1;
                    end else begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                    w_n   = {sym_q, sym_q};
                    vld_n = 1'b1;
                end
            end
            GAP: begin
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    cnt_n = cnt - CW'(1);
                    w_n   = (w == SYM_01) ? SYM_10 : SYM_01;
                    vld_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
            default: begin
                state_n = IDLE;
                rdy_n   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            gap_q   <= '0;
            sym_q   <= 1'b0;
            w       <= SYM_01;
            w_valid <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gap_q   <= gap_n;
            sym_q   <= sym_n;
            w       <= w_n;
            w_valid <= vld_n;
            ready   <= rdy_n;
            done    <= done_n;
        end
    end

    // Tracks the registered w exactly as the downstream detector will see it
    match_tracker #(
        .MIN_MATCH(MIN_MATCH)
    ) u_tracker (
        .Clock (Clock),
        .Reset (Reset),
        .w     (w),
        .z_exp (z_exp)
    );

endmodule

// File: tb/tb_match_seq_gen.sv
module tb_match_seq_gen;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       start;
    logic [3:0] run_len;
    logic       sym;
    logic [3:0] gap_len;
    logic       ready;
    logic [1:0] w;
    logic       w_valid;
    logic       z_exp;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clock = ~Clock;

    match_seq_gen #(.CW(4), .MIN_MATCH(4)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .start   (start),
        .run_len (run_len),
        .sym     (sym),
        .gap_len (gap_len),
        .ready   (ready),
        .w       (w),
        .w_valid (w_valid),
        .z_exp   (z_exp),
        .done    (done)
    );

    // Inputs applied before an edge, and the outputs expected just after it
    typedef struct {
        logic       start;
        logic [3:0] run_len;
        logic       sym;
        logic [3:0] gap_len;
        logic [1:0] w;
        logic       vld;
        logic       z;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input int rl, input logic sy, input int gl,
                       input logic [1:0] ew, input logic ev, input logic ez,
                       input logic ed, input logic er);
        vec_t v;
        v.start = st; v.run_len = 4'(rl); v.sym = sy; v.gap_len = 4'(gl);
        v.w = ew; v.vld = ev; v.z = ez; v.done = ed; v.rdy = er;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [1:0] act, input logic [1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %b expected %b", name, idx, act, exp);
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic [1:0] ew, input logic ev,
                                 input logic ez, input logic ed, input logic er);
        check({tag, ".w"},       idx, w,              ew);
        check({tag, ".w_valid"}, idx, {1'b0, w_valid}, {1'b0, ev});
        check({tag, ".z_exp"},   idx, {1'b0, z_exp},   {1'b0, ez});
        check({tag, ".done"},    idx, {1'b0, done},    {1'b0, ed});
        check({tag, ".ready"},   idx, {1'b0, ready},   {1'b0, er});
    endtask

    initial begin
        int bad;
        start = 0; run_len = 0; sym = 0; gap_len = 0;
        Reset = 1'b1;
        #12;
        check_outputs("reset", 0, 2'b01, 0, 0, 0, 1);
        Reset = 1'b0;
        @(posedge Clock); #1;

        //   st rl sy gl   w      vld z done rdy
        // run 4 of 00, gap 2
        add(1, 4, 0, 2, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);
        // run 6 of 11, no gap: z saturates high for 3 cycles
        add(1, 6, 1, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 1, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 1, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);
        // run 3 is below threshold: z never rises
        add(1, 3, 0, 3, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);
        // empty command straight to DONE; start during DONE is dropped
        add(1, 0, 0, 0, 2'b01, 0, 0, 1, 0);
        add(1, 5, 1, 0, 2'b01, 0, 0, 0, 1);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);
        // gap-only command
        add(1, 0, 1, 2, 2'b01, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b10, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);
        // back-to-back run 4 of 11: one z pulse each, 01 between
        add(1, 4, 1, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 1, 1, 0);
        add(1, 4, 1, 0, 2'b01, 0, 0, 0, 1);
        add(1, 4, 1, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b11, 1, 0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 1, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            start   = vecs[i].start;
            run_len = vecs[i].run_len;
            sym     = vecs[i].sym;
            gap_len = vecs[i].gap_len;
            @(posedge Clock); #1;
            check_outputs("vec", i, vecs[i].w, vecs[i].vld, vecs[i].z, vecs[i].done, vecs[i].rdy);
        end

        // Reset mid-RUN of an 8-long command
        start = 1; run_len = 4'd8; sym = 1; gap_len = 4'd2;
        @(posedge Clock); #1;
        start = 0;
        check_outputs("pre_reset", 0, 2'b11, 1, 0, 0, 0);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        check_outputs("mid_run", 0, 2'b11, 1, 1, 0, 0);
        #2 Reset = 1'b1;
        #1;
        check_outputs("in_reset", 0, 2'b01, 0, 0, 0, 1);
        @(posedge Clock); #1;
        Reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clock); #1;
            if (done !== 1'b0 || w_valid !== 1'b0 || ready !== 1'b1) bad++;
        end
        check("no_done_after_reset", 0, 2'(bad > 0), 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
